// File: rtl/level_sequencer.sv
// Game-flow controller: sequences enemy waves, gates enemy activity, times the
// between-wave intermission and reports win / game-over to the HUD.
module level_sequencer #(
  parameter int unsigned N_ENEMIES    = 5,
  parameter int unsigned MAX_LEVEL    = 9,
  parameter int unsigned PAUSE_CYCLES = 65_000_000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 player_dead,
  input  logic [N_ENEMIES-1:0] enemies_alive,
  output logic [3:0]           level,
  output logic                 level_up,
  output logic                 respawn,
  output logic                 enemies_en,
  output logic                 intermission,
  output logic                 game_won,
  output logic                 game_over
);

  localparam int unsigned TimerW = ($clog2(PAUSE_CYCLES + 1) < 1) ? 1 :
                                   $clog2(PAUSE_CYCLES + 1);
  localparam int unsigned GuardW = ($clog2(GUARD_CYCLES + 1) < 1) ? 1 :
                                   $clog2(GUARD_CYCLES + 1);

  localparam logic [TimerW-1:0] TimerLoad = TimerW'(PAUSE_CYCLES - 1);
  localparam logic [GuardW-1:0] GuardLoad = GuardW'(GUARD_CYCLES);
  localparam logic [3:0]        MaxLevel  = 4'(MAX_LEVEL);

  typedef enum logic [2:0] {
    StIdle,
    StRespawn,
    StPlay,
    StLevelUp,
    StPause,
    StWin,
    StOver
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          level_q, level_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [GuardW-1:0]   guard_q, guard_d;
  logic                level_up_q, respawn_q, enemies_en_q;
  logic                intermission_q, game_won_q, game_over_q;
  logic                wave_clear;

  // Clear detection is masked until the freshly respawned enemies report alive.
  assign wave_clear = (guard_q == '0) && (enemies_alive == '0);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    timer_d = timer_q;
    guard_d = guard_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRespawn;
          level_d = 4'd1;
        end
      end

      StRespawn: begin
        state_d = StPlay;
        guard_d = GuardLoad;
      end

      StPlay: begin
        if (guard_q != '0) begin
          guard_d = guard_q - 1'b1;
        end
        // Death wins over a simultaneous wave clear.
        if (player_dead) begin
          state_d = StOver;
        end else if (wave_clear) begin
          if (level_q == MaxLevel) begin
            state_d = StWin;
          end else begin
            state_d = StLevelUp;
            level_d = level_q + 4'd1;
          end
        end
      end

      StLevelUp: begin
        state_d = StPause;
        timer_d = TimerLoad;
      end

      StPause: begin
        if (timer_q == '0) begin
          state_d = StRespawn;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      StWin, StOver: begin
        if (start) begin
          state_d = StRespawn;
          level_d = 4'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move with the state register.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q        <= StIdle;
      level_q        <= 4'd1;
      timer_q        <= '0;
      guard_q        <= '0;
      level_up_q     <= 1'b0;
      respawn_q      <= 1'b0;
      enemies_en_q   <= 1'b0;
      intermission_q <= 1'b0;
      game_won_q     <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      timer_q        <= timer_d;
      guard_q        <= guard_d;
      level_up_q     <= (state_d == StLevelUp);
      respawn_q      <= (state_d == StRespawn);
      enemies_en_q   <= (state_d == StPlay);
      intermission_q <= (state_d == StPause);
      game_won_q     <= (state_d == StWin);
      game_over_q    <= (state_d == StOver);
    end
  end

  assign level        = level_q;
  assign level_up     = level_up_q;
  assign respawn      = respawn_q;
  assign enemies_en   = enemies_en_q;
  assign intermission = intermission_q;
  assign game_won     = game_won_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer: directed scenarios plus randomized
// waves checked against an arithmetic model of when each wave must end.
module tb_level_sequencer;

  localparam int N    = 5;
  localparam int MAXL = 3;
  localparam int P    = 4;
  localparam int G    = 2;

  logic         pclk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         player_dead = 1'b0;
  logic [N-1:0] enemies_alive = '1;
  logic [3:0]   level;
  logic         level_up, respawn, enemies_en, intermission, game_won, game_over;

  int n_tests = 0;
  int n_fail  = 0;

  level_sequencer #(
    .N_ENEMIES   (N),
    .MAX_LEVEL   (MAXL),
    .PAUSE_CYCLES(P),
    .GUARD_CYCLES(G)
  ) dut (
    .pclk         (pclk),
    .rst          (rst),
    .start        (start),
    .player_dead  (player_dead),
    .enemies_alive(enemies_alive),
    .level        (level),
    .level_up     (level_up),
    .respawn      (respawn),
    .enemies_en   (enemies_en),
    .intermission (intermission),
    .game_won     (game_won),
    .game_over    (game_over)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Walks from the LEVEL_UP cycle through the pause; optionally pokes start and
  // player_dead at loop index poke_at.
  task automatic pause_walk(input int poke_at, output int pause_cnt, output int overlap,
                            output bit saw_respawn);
    pause_cnt   = 0;
    overlap     = 0;
    saw_respawn = 1'b0;
    for (int i = 0; i < P + 8 && !saw_respawn; i++) begin
      start       = (i == poke_at);
      player_dead = (i == poke_at);
      tick();
      start       = 1'b0;
      player_dead = 1'b0;
      if (intermission) pause_cnt++;
      if (respawn && level_up) overlap++;
      if (respawn) saw_respawn = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({level, level_up, respawn, enemies_en, intermission, game_won, game_over} !==
        {4'd1, 6'b0}) begin
      n_fail++;
      $display("FAIL reset_hold: got level=%0d flags=%b, want level=1 flags=000000", level,
               {level_up, respawn, enemies_en, intermission, game_won, game_over});
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({level, level_up, respawn, enemies_en, intermission, game_won, game_over} !==
        {4'd1, 6'b0}) begin
      n_fail++;
      $display("FAIL reset_idle: got level=%0d flags=%b, want level=1 flags=000000", level,
               {level_up, respawn, enemies_en, intermission, game_won, game_over});
    end
  endtask

  task automatic test_start;
    pulse_start();
    n_tests++;
    if ({respawn, enemies_en, level} !== {1'b1, 1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL start_respawn: got respawn=%b en=%b level=%0d, want 1 0 1", respawn,
               enemies_en, level);
    end
    tick();
    n_tests++;
    if ({respawn, enemies_en, level} !== {1'b0, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL start_play: got respawn=%b en=%b level=%0d, want 0 1 1", respawn,
               enemies_en, level);
    end
  endtask

  task automatic test_wave_clear;
    int cnt, ovl;
    bit saw;
    enemies_alive = '1;
    repeat (G) tick();
    n_tests++;
    if ({enemies_en, level_up} !== 2'b10) begin
      n_fail++;
      $display("FAIL clear_pre: got en=%b level_up=%b, want 1 0", enemies_en, level_up);
    end
    enemies_alive = '0;
    tick();
    n_tests++;
    if ({level_up, level, enemies_en} !== {1'b1, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL clear_levelup: got level_up=%b level=%0d en=%b, want 1 2 0", level_up,
               level, enemies_en);
    end
    pause_walk(99, cnt, ovl, saw);
    n_tests++;
    if (cnt !== P || !saw || ovl !== 0) begin
      n_fail++;
      $display("FAIL clear_pause: got cycles=%0d respawn=%b overlap=%0d, want %0d 1 0", cnt,
               saw, ovl, P);
    end
    tick();
    n_tests++;
    if ({enemies_en, respawn, level} !== {1'b1, 1'b0, 4'd2}) begin
      n_fail++;
      $display("FAIL clear_replay: got en=%b respawn=%b level=%0d, want 1 0 2", enemies_en,
               respawn, level);
    end
  endtask

  // enemies_alive stays 0 through the respawn: clear only after the guard expires.
  task automatic test_guard;
    int edges, cnt, ovl;
    bit saw;
    edges = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      edges++;
      if (level_up) break;
    end
    n_tests++;
    if (edges !== G + 1 || level !== 4'd3) begin
      n_fail++;
      $display("FAIL guard_delay: got edges=%0d level=%0d, want %0d 3", edges, level, G + 1);
    end
    pause_walk(99, cnt, ovl, saw);
    tick();
    n_tests++;
    if (cnt !== P || !saw || enemies_en !== 1'b1) begin
      n_fail++;
      $display("FAIL guard_pause: got cycles=%0d respawn=%b en=%b, want %0d 1 1", cnt, saw,
               enemies_en, P);
    end
  endtask

  task automatic test_win_restart;
    int edges;
    edges = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      edges++;
      if (game_won) break;
    end
    n_tests++;
    if ({game_won, level, level_up, enemies_en} !== {1'b1, 4'd3, 1'b0, 1'b0} ||
        edges !== G + 1) begin
      n_fail++;
      $display("FAIL win: got won=%b level=%0d level_up=%b en=%b edges=%0d, want 1 3 0 0 %0d",
               game_won, level, level_up, enemies_en, edges, G + 1);
    end
    repeat (3) tick();
    n_tests++;
    if ({game_won, level, respawn, level_up} !== {1'b1, 4'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL win_sticky: got won=%b level=%0d respawn=%b level_up=%b, want 1 3 0 0",
               game_won, level, respawn, level_up);
    end
    pulse_start();
    n_tests++;
    if ({game_won, level, respawn} !== {1'b0, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL win_restart: got won=%b level=%0d respawn=%b, want 0 1 1", game_won,
               level, respawn);
    end
    tick();
  endtask

  task automatic test_simultaneous;
    int cnt, ovl;
    bit saw;
    enemies_alive = '1;
    repeat (G) tick();
    enemies_alive = '0;
    player_dead   = 1'b1;
    tick();
    player_dead = 1'b0;
    n_tests++;
    if ({game_over, level, level_up, enemies_en, game_won} !==
        {1'b1, 4'd1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL dead_and_clear: got over=%b level=%0d level_up=%b en=%b won=%b, want 1 1 0 0 0",
               game_over, level, level_up, enemies_en, game_won);
    end
    tick();
    pulse_start();
    n_tests++;
    if ({game_over, respawn} !== 2'b01) begin
      n_fail++;
      $display("FAIL over_restart: got over=%b respawn=%b, want 0 1", game_over, respawn);
    end
    tick();
    enemies_alive = '1;
    repeat (G) tick();
    enemies_alive = '0;
    tick();
    enemies_alive = '1;
    pause_walk(2, cnt, ovl, saw);
    n_tests++;
    if (cnt !== P || !saw || level !== 4'd2 || game_over !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_ignores_start: got cycles=%0d respawn=%b level=%0d over=%b, want %0d 1 2 0",
               cnt, saw, level, game_over, P);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int hits;
    repeat (G) tick();
    enemies_alive = '0;
    tick();
    enemies_alive = '1;
    tick();
    tick();
    n_tests++;
    if ({intermission, level} !== {1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL mid_pre: got intermission=%b level=%0d, want 1 3", intermission, level);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_tests++;
    if ({level, level_up, respawn, enemies_en, intermission, game_won, game_over} !==
        {4'd1, 6'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got level=%0d flags=%b, want level=1 flags=000000", level,
               {level_up, respawn, enemies_en, intermission, game_won, game_over});
    end
    hits = 0;
    repeat (P + 3) begin
      tick();
      if (respawn || enemies_en || intermission) hits++;
    end
    n_tests++;
    if (hits !== 0) begin
      n_fail++;
      $display("FAIL mid_stays_idle: got %0d active cycles, want 0", hits);
    end
    pulse_start();
    n_tests++;
    if ({respawn, level} !== {1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL mid_restart: got respawn=%b level=%0d, want 1 1", respawn, level);
    end
    tick();
  endtask

  // Each wave: enemies all die from PLAY cycle k onward, player may die at cycle d.
  // The wave ends at cycle max(k, G) by clear, or earlier/same cycle by death.
  task automatic test_random;
    int lvl, k, d, fire, cnt, ovl;
    bit saw;
    lvl = 1;
    for (int w = 0; w < 25; w++) begin
      n_tests++;
      if ({enemies_en, level} !== {1'b1, 4'(lvl)}) begin
        n_fail++;
        $display("FAIL rand_entry w=%0d: got en=%b level=%0d, want 1 %0d", w, enemies_en,
                 level, lvl);
      end
      k    = int'($urandom_range(0, 5));
      d    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 99;
      fire = (k > G) ? k : G;
      for (int j = 0; j <= fire; j++) begin
        enemies_alive = (j >= k) ? '0 : N'($urandom_range(1, 31));
        player_dead   = (j == d);
        tick();
        player_dead = 1'b0;
        n_tests++;
        if (j == d) begin
          if ({game_over, game_won, level_up, enemies_en, level} !==
              {4'b1000, 4'(lvl)}) begin
            n_fail++;
            $display("FAIL rand_over w=%0d j=%0d: got over=%b won=%b lu=%b en=%b level=%0d, want 1 0 0 0 %0d",
                     w, j, game_over, game_won, level_up, enemies_en, level, lvl);
          end
          break;
        end else if (j == fire) begin
          if (lvl == MAXL) begin
            if ({game_won, game_over, level_up, enemies_en, level} !==
                {4'b1000, 4'(lvl)}) begin
              n_fail++;
              $display("FAIL rand_win w=%0d: got won=%b over=%b lu=%b en=%b level=%0d, want 1 0 0 0 %0d",
                       w, game_won, game_over, level_up, enemies_en, level, lvl);
            end
          end else begin
            lvl++;
            if ({level_up, game_won, game_over, enemies_en, level} !==
                {4'b1000, 4'(lvl)}) begin
              n_fail++;
              $display("FAIL rand_levelup w=%0d: got lu=%b won=%b over=%b en=%b level=%0d, want 1 0 0 0 %0d",
                       w, level_up, game_won, game_over, enemies_en, level, lvl);
            end
          end
        end else begin
          if ({enemies_en, level_up, game_over, game_won, level} !==
              {4'b1000, 4'(lvl)}) begin
            n_fail++;
            $display("FAIL rand_play w=%0d j=%0d: got en=%b lu=%b over=%b won=%b level=%0d, want 1 0 0 0 %0d",
                     w, j, enemies_en, level_up, game_over, game_won, level, lvl);
          end
        end
      end
      enemies_alive = '1;
      if (level_up) begin
        pause_walk(99, cnt, ovl, saw);
        n_tests++;
        if (cnt !== P || !saw || ovl !== 0) begin
          n_fail++;
          $display("FAIL rand_pause w=%0d: got cycles=%0d respawn=%b overlap=%0d, want %0d 1 0",
                   w, cnt, saw, ovl, P);
        end
      end else begin
        pulse_start();
        lvl = 1;
        n_tests++;
        if ({respawn, game_won, game_over, level} !== {3'b100, 4'd1}) begin
          n_fail++;
          $display("FAIL rand_restart w=%0d: got respawn=%b won=%b over=%b level=%0d, want 1 0 0 1",
                   w, respawn, game_won, game_over, level);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_wave_clear();
    test_guard();
    test_win_restart();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
Name: level_sequencer

Overview:
- Game-flow controller that sequences enemy waves.
- Starts a game, issues the enemy respawn pulse and gates enemy movement and firing.
- Detects wave clear, advances the level, and holds a timed intermission between waves.
- Declares win at the top level or game-over on player death. Sits between the enemy modules (which supply per-enemy alive flags and consume respawn/enable/level) and the HUD/VGA overlay (which consumes level, level_up and the game status flags).

Parameters:
- N_ENEMIES, 5, number of enemy alive flags.
- MAX_LEVEL, 9, last level; clearing it means the game is won (1..15).
- PAUSE_CYCLES, 65_000_000, intermission length in pclk cycles (1 s at 65 MHz; must be ≥1).
- GUARD_CYCLES, 2, PLAY cycles during which wave-clear detection is masked after a respawn (≥1).

Ports:
- pclk  in  1  system pixel clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets the block).
- start  in  1  one-cycle start/restart request.
- player_dead  in  1  level-sensitive player-destroyed flag.
- enemies_alive  in  N_ENEMIES  per-enemy alive flags (1 = alive).
- level  out  4  current level, 1-based.
- level_up  out  1  one-cycle pulse when level increments.
- respawn  out  1  one-cycle pulse telling the enemy modules to reload lives for the current level.
- enemies_en  out  1  enemies may move and fire.
- intermission  out  1  between-wave pause active, for the HUD.
- game_won  out  1  sticky win flag.
- game_over  out  1  sticky loss flag.

Behaviour:
- Reset values: state IDLE, level=1, all other outputs 0, timer=0, guard=0. Reset overrides every other input on the same edge, including mid-intermission or mid-respawn.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state register.
- States: IDLE, RESPAWN, PLAY, LEVEL_UP, INTERMISSION, WIN, OVER.
- IDLE:
  - start=1 → RESPAWN with level=1.
  - Otherwise stay in IDLE.
- RESPAWN:
  - respawn=1 for exactly one cycle; guard loaded with GUARD_CYCLES.
  - Next state is PLAY unconditionally.
- PLAY:
  - enemies_en=1; guard decrements to 0 and saturates there.
  - Priority 1: player_dead=1 → OVER (game_over=1, enemies_en=0). This applies even when all enemies are dead on the same edge.
  - Priority 2: guard==0 and enemies_alive==0:
    - level==MAX_LEVEL → WIN (game_won=1, enemies_en=0).
    - Otherwise → LEVEL_UP.
  - start is ignored in PLAY.
- LEVEL_UP:
  - Lasts one cycle; level increments by 1 with no wrap, because MAX_LEVEL bounds it.
  - level_up=1 and enemies_en=0.
  - Next state is INTERMISSION, with timer loaded to PAUSE_CYCLES-1.
- INTERMISSION:
  - intermission=1, enemies_en=0; timer decrements once per cycle.
  - On the cycle timer==0 → RESPAWN. Intermission therefore lasts exactly PAUSE_CYCLES cycles.
  - player_dead and start are ignored.
- WIN and OVER:
  - Both are sticky; all outputs hold except the pulse outputs, which stay 0.
  - start=1 → clear game_won/game_over, set level=1 → RESPAWN.
- Timer width is $clog2(PAUSE_CYCLES+1) with a minimum of 1.
- respawn and level_up are never high in the same cycle.
- Latency:
  - Clear condition sampled at edge E → level_up high after edge E.
  - respawn high after edge E+1+PAUSE_CYCLES.
  - enemies_en high after edge E+2+PAUSE_CYCLES.

Test Plan:
Bench parameters: N_ENEMIES=5, MAX_LEVEL=3, PAUSE_CYCLES=4, GUARD_CYCLES=2.
- Reset/start: hold rst=0 for 3 cycles, then release → level=1, all flags 0. Pulse start → respawn=1 for 1 cycle, then enemies_en=1, level=1.
- Wave clear: in PLAY, drive enemies_alive 5'b11111 → 5'b00000 → level_up for 1 cycle, level=2, intermission=1 for exactly 4 cycles, then respawn for 1 cycle, then enemies_en=1.
- Guard: hold enemies_alive=0 through respawn → no level_up during the first 2 PLAY cycles; level_up occurs only after the guard expires.
- Win/restart: clear levels 1, 2, 3 → after the third clear, game_won=1, level stays 3, no level_up. Pulse start → game_won=0, level=1, respawn pulse.
- Simultaneous events: in PLAY, drive player_dead=1 and enemies_alive=0 on the same edge → game_over=1, level unchanged, no level_up. Pulse start during INTERMISSION → ignored, and the 4-cycle pause completes.
- Reset mid-operation: assert rst=0 during intermission with timer=2 → on the next edge level=1, intermission=0, state IDLE; respawn does not occur until start.
